// File: rtl/ifid_pkg.sv
// Shared defaults, fill-state encoding and entry record for the IF/ID skid buffer.
package ifid_pkg;

    localparam int unsigned IFID_INS_W = 32;
    localparam int unsigned IFID_PC_W  = 32;
    localparam int unsigned IFID_CNT_W = 16;

    localparam logic [IFID_INS_W-1:0] IFID_NOP_INS = '0;

    typedef struct packed {
        logic [IFID_INS_W-1:0] ins;
        logic [IFID_PC_W-1:0]  pc;
    } ifidEntry_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_FULL  = 2'd2
    } fillState_t;

endpackage

// File: rtl/ifid_skid_buf_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ifid_skid_buf.sv
// Two-entry IF/ID skid buffer with flush; in_ready depends only on the stored count.
// Optional stall/flush performance counters are enabled by defining IFID_PERF_EN.
module ifid_skid_buf
    import ifid_pkg::*;
#(
    parameter int unsigned      INS_W   = IFID_INS_W,
    parameter int unsigned      PC_W    = IFID_PC_W,
    parameter logic [INS_W-1:0] NOP_INS = INS_W'(IFID_NOP_INS),
    parameter int unsigned      CNT_W   = IFID_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INS_W-1:0] InsIn,
    input  logic [PC_W-1:0]  PC_In,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INS_W-1:0] InsOut,
    output logic [PC_W-1:0]  PC_out,
    input  logic             IF_flush,
    output logic [1:0]       occupancy
`ifdef IFID_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef struct packed {
        logic [INS_W-1:0] ins;
        logic [PC_W-1:0]  pc;
    } entry_t;

    fillState_t fill, fillNext;
    entry_t     head, tail, headNext, tailNext, incoming;
    logic       inReadyQ;
    logic       push, pop;

    assign incoming = '{ins: InsIn, pc: PC_In};
    assign push     = in_valid & inReadyQ & ~IF_flush;
    assign pop      = (fill != FILL_EMPTY) & out_ready & ~IF_flush;

    always_comb begin
        fillNext = fill;
        headNext = head;
        tailNext = tail;
        if (IF_flush) begin
            fillNext = FILL_EMPTY;
        end else begin
            case (fill)
                FILL_EMPTY: begin
                    if (push) begin
                        headNext = incoming;
                        fillNext = FILL_ONE;
                    end
                end
                FILL_ONE: begin
                    // Push with pop replaces the head in place; push alone fills the tail.
                    if (push && pop) begin
                        headNext = incoming;
                    end else if (push) begin
                        tailNext = incoming;
                        fillNext = FILL_FULL;
                    end else if (pop) begin
                        fillNext = FILL_EMPTY;
                    end
                end
                FILL_FULL: begin
                    if (pop) begin
                        headNext = tail;
                        fillNext = FILL_ONE;
                    end
                end
                default: fillNext = FILL_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill     <= FILL_EMPTY;
            head     <= '0;
            tail     <= '0;
            inReadyQ <= 1'b1;
        end else begin
            fill     <= fillNext;
            head     <= headNext;
            tail     <= tailNext;
            inReadyQ <= (fillNext != FILL_FULL);
        end
    end

    assign in_ready  = inReadyQ;
    assign out_valid = (fill != FILL_EMPTY);
    assign InsOut    = out_valid ? head.ins : NOP_INS;
    assign PC_out    = out_valid ? head.pc : '0;
    assign occupancy = fill;

`ifdef IFID_PERF_EN
    sat_counter #(.CNT_W(CNT_W)) uStallCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (IF_flush & out_valid),
        .count (flush_cnt)
    );
`endif

endmodule

// File: doc/ifid_skid_buf.md
IFID_SKID_BUF -- requirements
Module: ifid_skid_buf

Interface
REQ-001 The block SHALL have parameter INS_W, default 32, meaning the instruction word width.
REQ-002 The block SHALL have parameter PC_W, default 32, meaning the program-counter width.
REQ-003 The block SHALL have parameter NOP_INS, default 0 (INS_W bits), meaning the instruction presented when the block is empty.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning the performance-counter width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the fetch stage offers a word.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-009 The block SHALL have ports InsIn (input, INS_W) and PC_In (input, PC_W): the fetched instruction and its PC.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the head entry is valid for decode.
REQ-011 The block SHALL have port out_ready, input, 1 bit: decode consumes the head.
REQ-012 The block SHALL have ports InsOut (output, INS_W) and PC_out (output, PC_W): the head instruction and PC.
REQ-013 The block SHALL have port IF_flush, input, 1 bit: discard all buffered and incoming words.
REQ-014 The block SHALL have port occupancy, output, 2 bits: number of entries held (0..2).
REQ-015 With IFID_PERF_EN defined, the block SHALL have ports stall_cnt and flush_cnt, outputs, CNT_W bits each.

Function
REQ-016 The storage SHALL be a 2-entry in-order buffer (head, tail); occupancy SHALL equal the entry count.
REQ-017 in_ready SHALL be a registered function of the count only (1 when count<2), with no combinational path from out_ready.
REQ-018 A push SHALL occur when in_valid & in_ready & ~IF_flush.
REQ-019 out_valid SHALL be 1 exactly when count!=0; a pop SHALL occur when out_valid & out_ready & ~IF_flush.
REQ-020 When count=0, InsOut SHALL equal NOP_INS and PC_out SHALL equal 0.
REQ-021 Latency SHALL be one cycle: a word pushed at edge N SHALL appear on InsOut/PC_out after edge N when the buffer was empty.
REQ-022 Simultaneous push and pop at count=1 SHALL leave count at 1, with the new word at the head on the next cycle.
REQ-023 At count=2, in_ready=0 and no push SHALL occur even if a pop occurs that cycle; count becomes 1.
REQ-024 Words SHALL leave in arrival order; no word SHALL be duplicated or lost except by flush.
REQ-025 IF_flush=1 SHALL set count to 0 at the next edge, dropping the same-cycle input and ignoring out_ready; flush takes priority over push and pop.

Reset
REQ-026 reset=1 at an edge SHALL clear count to 0 and both entries to zero, giving out_valid=0, InsOut=NOP_INS, PC_out=0, in_ready=1, occupancy=0.
REQ-027 reset SHALL take priority over IF_flush, push and pop. Reset mid-stream SHALL discard buffered words with no output of partial data.
REQ-028 With IFID_PERF_EN defined, reset SHALL clear stall_cnt and flush_cnt to 0.

Configuration
REQ-029 Macro IFID_PERF_EN defined: stall_cnt SHALL increment each cycle with out_valid & ~out_ready; flush_cnt SHALL increment each cycle IF_flush=1 and count!=0. Both SHALL saturate at all-ones.
REQ-030 Macro IFID_PERF_EN undefined: the counter ports and logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-031 Package ifid_pkg SHALL hold the default widths, the NOP_INS constant and the entry record typedef {ins, pc}.
REQ-032 The saturating counter SHALL be one sub-module, sat_counter (parameter CNT_W), instantiated twice under IFID_PERF_EN.

Verification
REQ-033 Reset then idle: out_valid=0, InsOut=0x00000000, PC_out=0, in_ready=1, occupancy=0.
REQ-034 Push 0x8C220004/PC 0x00400000 with out_ready=1: appears on InsOut the next cycle, out_valid=1, then drains to NOP.
REQ-035 Hold out_ready=0 and push 3 words: first two accepted, in_ready=0 at occupancy=2, third held. Then out_ready=1: all three emerge in order.
REQ-036 Occupancy=2 with IF_flush=1 and in_valid=1: next cycle occupancy=0, out_valid=0, and the flushing-cycle input never appears.
REQ-037 Under IFID_PERF_EN, CNT_W=4 with out_ready=0 and out_valid=1 for 20 cycles: stall_cnt saturates at 15; reset clears it to 0.
REQ-038 1000 cycles of random in_valid/out_ready/IF_flush (seed 1): output sequence matches a scoreboard queue model exactly.
